// File: rtl/bs_pkg.sv
// Shared types and helpers for the per-player Battleship controller.
package bs_pkg;

    localparam int DEF_GRID_W = 4;
    localparam int DEF_GRID_H = 4;

    typedef enum logic [2:0] {
        PLACE     = 3'd0,
        WAIT_PEER = 3'd1,
        FIRE      = 3'd2,
        SEND      = 3'd3,
        DEFEND    = 3'd4,
        WON       = 3'd5,
        LOST      = 3'd6
    } state_t;

    function automatic logic is_onehot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/bs_popcount.sv
// Combinational population count: pairwise adder tree over a power-of-two padded input.
module bs_popcount
    import bs_pkg::*;
#(
    parameter int N = 16,
    localparam int OW = $clog2(N + 1)
) (
    input  logic [N-1:0]  din,
    output logic [OW-1:0] count
);

    localparam int P = (N <= 1) ? 1 : (1 << $clog2(N));

    logic [OW-1:0] leaf [P];
    logic [OW-1:0] acc  [P];

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < N) begin : g_real
                assign leaf[gi] = OW'(din[gi]);
            end else begin : g_pad
                assign leaf[gi] = '0;
            end
        end
    endgenerate

    // Each pass halves the number of partial sums; subtree sums never exceed N.
    always_comb begin
        acc = leaf;
        for (int s = P / 2; s >= 1; s = s / 2) begin
            for (int i = 0; i < s; i++) begin
                acc[i] = acc[2*i] + acc[2*i+1];
            end
        end
        count = acc[0];
    end

endmodule

// File: rtl/bs_player_ctrl.sv
// One player's Battleship board: placement check, fire/defend turn sequence,
// life tracking and the valid/ready shot channels to the opponent.
module bs_player_ctrl
    import bs_pkg::*;
#(
    parameter int GRID_W     = DEF_GRID_W,
    parameter int GRID_H     = DEF_GRID_H,
    parameter int SHIP_CELLS = 5,
    parameter bit FIRST      = 1'b1,
    localparam int CELLS = GRID_W * GRID_H,
    localparam int LW    = $clog2(SHIP_CELLS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CELLS-1:0] sw,
    input  logic             ldr_place,
    input  logic             ldr_fire,
    input  logic             peer_ready,
    input  logic             peer_dead,
    input  logic             atk_in_valid,
    input  logic [CELLS-1:0] atk_in,
    output logic             atk_in_ready,
    output logic             atk_out_valid,
    output logic [CELLS-1:0] atk_out,
    input  logic             atk_out_ready,
    output logic             hit,
    output logic             err,
    output logic [LW-1:0]    lives,
    output logic             ok,
    output logic             alive,
    output state_t           state
);

    localparam int PCW = $clog2(CELLS + 1);

    state_t           state_q, state_d;
    logic [CELLS-1:0] board_q, board_d;
    logic [CELLS-1:0] hits_q, hits_d;
    logic [CELLS-1:0] fired_q, fired_d;
    logic [CELLS-1:0] atk_out_q, atk_out_d;
    logic             atk_out_valid_q, atk_out_valid_d;
    logic [LW-1:0]    lives_q, lives_d;
    logic             ok_q, ok_d;
    logic             alive_q, alive_d;
    logic             hit_q, hit_d;
    logic             err_q, err_d;

    logic [PCW-1:0]   place_cnt;
    logic             sw_onehot;
    logic             in_onehot;
    logic [CELLS-1:0] fresh_hit;

    bs_popcount #(.N(CELLS)) u_popcount (
        .din   (sw),
        .count (place_cnt)
    );

    assign sw_onehot = is_onehot(64'(sw));
    assign in_onehot = is_onehot(64'(atk_in));
    assign fresh_hit = board_q & atk_in & ~hits_q;

    always_comb begin
        state_d         = state_q;
        board_d         = board_q;
        hits_d          = hits_q;
        fired_d         = fired_q;
        atk_out_d       = atk_out_q;
        atk_out_valid_d = atk_out_valid_q;
        lives_d         = lives_q;
        ok_d            = ok_q;
        hit_d           = 1'b0;
        err_d           = 1'b0;

        if (clr) begin
            state_d         = PLACE;
            board_d         = '0;
            hits_d          = '0;
            fired_d         = '0;
            atk_out_d       = '0;
            atk_out_valid_d = 1'b0;
            lives_d         = '0;
            ok_d            = 1'b0;
        end else begin
            case (state_q)
                PLACE: begin
                    if (ldr_place) begin
                        if (place_cnt == PCW'(SHIP_CELLS)) begin
                            board_d = sw;
                            lives_d = LW'(SHIP_CELLS);
                            ok_d    = 1'b1;
                            state_d = WAIT_PEER;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                WAIT_PEER: begin
                    if (peer_ready) state_d = FIRST ? FIRE : DEFEND;
                end
                FIRE: begin
                    if (peer_dead) begin
                        state_d = WON;
                    end else if (ldr_fire) begin
                        if (sw_onehot && ((sw & fired_q) == '0)) begin
                            atk_out_d       = sw;
                            fired_d         = fired_q | sw;
                            atk_out_valid_d = 1'b1;
                            state_d         = SEND;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (peer_dead) begin
                        atk_out_valid_d = 1'b0;
                        state_d         = WON;
                    end else if (atk_out_ready) begin
                        atk_out_valid_d = 1'b0;
                        state_d         = DEFEND;
                    end
                end
                DEFEND: begin
                    // A malformed or repeated shot still ends the defending turn as a miss.
                    if (atk_in_valid) begin
                        if (!in_onehot) begin
                            err_d = 1'b1;
                        end else if (fresh_hit != '0) begin
                            hits_d = hits_q | atk_in;
                            hit_d  = 1'b1;
                            if (lives_q != '0) lives_d = lives_q - LW'(1);
                        end
                        if (peer_dead)            state_d = WON;
                        else if (lives_d == '0)   state_d = LOST;
                        else                      state_d = FIRE;
                    end else if (peer_dead) begin
                        state_d = WON;
                    end
                end
                WON, LOST: ;
                default: state_d = PLACE;
            endcase
        end

        alive_d = ok_d && (lives_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= PLACE;
            board_q         <= '0;
            hits_q          <= '0;
            fired_q         <= '0;
            atk_out_q       <= '0;
            atk_out_valid_q <= 1'b0;
            lives_q         <= '0;
            ok_q            <= 1'b0;
            alive_q         <= 1'b0;
            hit_q           <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            board_q         <= board_d;
            hits_q          <= hits_d;
            fired_q         <= fired_d;
            atk_out_q       <= atk_out_d;
            atk_out_valid_q <= atk_out_valid_d;
            lives_q         <= lives_d;
            ok_q            <= ok_d;
            alive_q         <= alive_d;
            hit_q           <= hit_d;
            err_q           <= err_d;
        end
    end

    assign atk_in_ready  = (state_q == DEFEND);
    assign atk_out_valid = atk_out_valid_q;
    assign atk_out       = atk_out_q;
    assign hit           = hit_q;
    assign err           = err_q;
    assign lives         = lives_q;
    assign ok            = ok_q;
    assign alive         = alive_q;
    assign state         = state_q;

endmodule

// File: doc/bs_player_ctrl.md
# bs_player_ctrl

Parametrised per-player Battleship controller: holds one player's ship map on a GRID_W×GRID_H grid, validates placement, and runs the turn sequence (fire / defend) over valid/ready attack channels. It tracks remaining lives, and shots already fired, in registers. One instance serves each board (master and slave), replacing the fixed 16-cell, unclocked player top. Display decoding stays outside; this block exports lives and state only.

## Interface
- GRID_W, 4, grid columns (2..8)
- GRID_H, 4, grid rows (2..8)
- SHIP_CELLS, 5, number of cells a valid placement must occupy (1..CELLS)
- FIRST, 1, 1 = this player fires first after both boards are ready; 0 = defends first
- Derived: CELLS = GRID_W*GRID_H; LW = $clog2(SHIP_CELLS+1)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous game clear (level, sampled each cycle)
- sw  in  CELLS  placement map in PLACE state; target cell selector (must be one-hot) in FIRE state
- ldr_place  in  1  debounced single-cycle pulse: commit placement
- ldr_fire  in  1  debounced single-cycle pulse: fire at sw
- peer_ready  in  1  opponent's board is committed (level)
- peer_dead  in  1  opponent has lost (level)
- atk_in_valid  in  1  incoming shot valid
- atk_in  in  CELLS  incoming shot, one-hot
- atk_in_ready  out  1  shot accepted this cycle when high with atk_in_valid
- atk_out_valid  out  1  outgoing shot valid
- atk_out  out  CELLS  outgoing shot, one-hot
- atk_out_ready  in  1  opponent accepts outgoing shot
- hit  out  1  one-cycle pulse: accepted incoming shot struck an unhit ship cell
- err  out  1  one-cycle pulse: rejected request (bad placement, bad target, malformed incoming shot)
- lives  out  LW  remaining unhit ship cells
- ok  out  1  placement committed and valid
- alive  out  1  lives != 0 and ok
- state  out  3  current state code (bs_pkg::state_t)

## Operation
- States: PLACE, WAIT_PEER, FIRE, SEND, DEFEND, WON, LOST.
- PLACE: on ldr_place, if popcount(sw)==SHIP_CELLS then board<=sw, lives<=SHIP_CELLS, ok<=1, go WAIT_PEER; else err pulse, stay.
- WAIT_PEER: when peer_ready, go FIRE if FIRST=1, else DEFEND.
- FIRE: on ldr_fire, sw must be one-hot and its bit clear in fired map; else err pulse, stay. Valid: atk_out<=sw, fired|=sw, go SEND.
- SEND: atk_out_valid=1, atk_out stable until atk_out_ready; on handshake go DEFEND.
- DEFEND: atk_in_ready=1. On atk_in_valid: if atk_in not one-hot, err pulse, shot consumed as a miss. Else if board&atk_in&~hits nonzero: hits|=atk_in, lives-1, hit pulse. Repeat shots on already-hit cells count as a miss. Then go LOST if new lives==0, else FIRE.
- peer_dead in FIRE, SEND or DEFEND: go WON (priority over all other transitions except clr and reset).
- WON/LOST: terminal; only clr or reset leaves.
- clr: from any state go PLACE; board, hits, fired, lives, ok cleared; atk_out_valid dropped even mid-handshake.
- lives never underflows. Decrement only when a unique ship cell is hit.

## Timing
- Reset values: state=PLACE; board, hits, fired, atk_out = 0; lives=0; ok, alive, hit, err, atk_out_valid, atk_in_ready = 0.
- All outputs are registered except atk_in_ready, which is decoded from state (Moore).
- Latency: ldr_place → ok high 1 cycle later. ldr_fire → atk_out_valid high 1 cycle later. Incoming handshake → hit, lives and state updated 1 cycle later.
- One shot per DEFEND visit; atk_in_ready drops the cycle after the handshake.
- ldr_fire outside FIRE and ldr_place outside PLACE are ignored (no err).

## Structure
- Package bs_pkg: state_t enum (3-bit, codes PLACE=0 … LOST=6), function is_onehot, constants for default GRID_W/GRID_H.
- Sub-module bs_popcount #(N) (combinational adder tree, $clog2(N+1) output), used for placement check.
- Board, hits and fired are CELLS-wide registers; no memories.

## Test plan
- 4×4, SHIP_CELLS=5: ldr_place with sw=16'h001F → ok=1, lives=5; sw=16'h000F → err pulse, stays PLACE.
- FIRST=1, peer_ready=1, sw=16'h0100, ldr_fire → atk_out_valid next cycle, atk_out=16'h0100 held through 3 cycles of atk_out_ready=0, then handshake → DEFEND.
- DEFEND, board 16'h001F: atk_in=16'h0004 → hit pulse, lives 5→4. Same cell again → no hit, lives stays 4, state FIRE.
- Fire again at 16'h0100 → err, no SEND. sw=16'h0300 (two bits) → err.
- Five unique hits → lives=0, state LOST, alive=0. Then clr → PLACE, all registers zero.
- rst_n low mid-SEND → outputs reset asynchronously. GRID_W=8, GRID_H=8, SHIP_CELLS=17 run → lives width 5, same sequences pass.
